// File: rtl/alct_gbt_pkg.sv
// Shared definitions for the ALCT GBT frame builder: frame geometry, headers,
// FSM state encoding and LCT word field offsets.
// Used by alct_daq_wide_fifo, alct_gbt_frame_builder and their bench.
package alct_gbt_pkg;

  localparam int FRAME_W = 112;
  localparam int SLOT_W  = 8;
  localparam int N_SLOTS = 7;
  localparam int LCT_W   = 14;
  localparam int BX_W    = 12;

  // LCT word: {valid, quality[1:0], amu, key[6:0], bxn[2:0]}
  localparam int LCT_BXN_LSB   = 0;
  localparam int LCT_KEY_LSB   = 3;
  localparam int LCT_AMU_BIT   = 10;
  localparam int LCT_QUAL_LSB  = 11;
  localparam int LCT_VALID_BIT = 13;

  localparam logic [3:0] HDR_IDLE = 4'b0110;
  localparam logic [3:0] HDR_SYNC = 4'b1010;
  localparam logic [3:0] HDR_RUN  = 4'b0101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Slot 0 is the oldest queued DAQ word.
  typedef logic [N_SLOTS-1:0][SLOT_W-1:0] daq_window_t;

  function automatic logic [3:0] state_header(input state_t s);
    case (s)
      SYNC:    return HDR_SYNC;
      RUN:     return HDR_RUN;
      default: return HDR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/alct_daq_wide_fifo.sv
// DAQ word FIFO: one write per cycle, up to N_SLOTS pops per cycle, 7-slot read window.
// Latency: a written word is visible in count/window the cycle after the write.
// Backpressure: none upstream; a write while full is silently discarded (caller flags it).
// Ports: clock/nreset; wr_en/wr_data write side; pop_n (must be <= count);
//        count, full, window (oldest entry in slot 0).
module alct_daq_wide_fifo
  import alct_gbt_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic                   wr_en,
  input  logic [SLOT_W-1:0]      wr_data,
  input  logic [2:0]             pop_n,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output daq_window_t            window
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [SLOT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;

  assign full  = (count == CW'(DEPTH));
  assign wr_ok = wr_en && !full;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count - CW'(pop_n) + CW'(wr_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Slots beyond count hold stale data; the consumer masks them.
  always_comb begin
    window = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      window[i] = mem[rd_ptr + AW'(i)];
    end
  end

endmodule

// File: rtl/alct_gbt_frame_builder.sv
// Packs two LCTs plus up to 7 DAQ words into one 112-bit GBT frame per BX.
// Latency: LCT in -> frame 2 edges (1 input reg + frame reg); DAQ write -> earliest pop 2 edges later.
// Backpressure: gbt_txrdy low drops to IDLE and DAQ words queue; overflow drops words, sets sticky flag.
// Ports: clock/nreset; gbt_txrdy, bc0; lct0_word/lct1_word; daq_we/daq_data/daq_special;
//        frame, gbt_tx_datavalid, daq_overflow, state_dbg.
module alct_gbt_frame_builder
  import alct_gbt_pkg::*;
#(
  parameter int DAQ_DEPTH   = 64,
  parameter int SYNC_FRAMES = 16,
  parameter int BX_MAX      = 3563
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic               gbt_txrdy,
  input  logic               bc0,
  input  logic [LCT_W-1:0]   lct0_word,
  input  logic [LCT_W-1:0]   lct1_word,
  input  logic               daq_we,
  input  logic [6:0]         daq_data,
  input  logic               daq_special,
  output logic [FRAME_W-1:0] frame,
  output logic               gbt_tx_datavalid,
  output logic               daq_overflow,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(DAQ_DEPTH) + 1;
  localparam int SW = $clog2(SYNC_FRAMES + 1);

  state_t             state_q;
  state_t             state_d;
  logic [SW-1:0]      sync_cnt;
  logic [BX_W-1:0]    bx_cnt;
  logic [LCT_W-1:0]   lct0_q;
  logic [LCT_W-1:0]   lct1_q;
  logic               daq_vld_q;
  logic [SLOT_W-1:0]  daq_dat_q;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  daq_window_t        window;
  logic [2:0]         pop_n;
  logic [FRAME_W-1:0] frame_d;

  assign state_dbg = state_q;

  // Input stage: registering DAQ writes here is what keeps a new word out of
  // the pop decision until the edge after it reaches the FIFO.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      lct0_q    <= '0;
      lct1_q    <= '0;
      daq_vld_q <= 1'b0;
      daq_dat_q <= '0;
    end else begin
      lct0_q    <= lct0_word;
      lct1_q    <= lct1_word;
      daq_vld_q <= daq_we;
      daq_dat_q <= {daq_special, daq_data};
    end
  end

  alct_daq_wide_fifo #(.DEPTH(DAQ_DEPTH)) u_fifo (
    .clock   (clock),
    .nreset  (nreset),
    .wr_en   (daq_vld_q),
    .wr_data (daq_dat_q),
    .pop_n   (pop_n),
    .count   (fifo_count),
    .full    (fifo_full),
    .window  (window)
  );

  // FSM state register; sync_cnt counts SYNC frames already emitted.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      sync_cnt <= '0;
    end else begin
      state_q  <= state_d;
      sync_cnt <= (state_q == SYNC && state_d == SYNC) ? sync_cnt + SW'(1) : '0;
    end
  end

  // FSM next state; losing the link always wins.
  always_comb begin
    state_d = state_q;
    if (!gbt_txrdy) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = SYNC;
        SYNC:    if (sync_cnt == SW'(SYNC_FRAMES - 1)) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: pop count and next frame contents.
  always_comb begin
    pop_n = '0;
    if (state_q == RUN) begin
      pop_n = (fifo_count >= CW'(N_SLOTS)) ? 3'(N_SLOTS) : fifo_count[2:0];
    end

    frame_d           = '0;
    frame_d[111:108]  = state_header(state_q);
    frame_d[107:96]   = bx_cnt;
    if (state_q == RUN) begin
      frame_d[95:80]  = {2'b00, lct0_q};
      frame_d[79:64]  = {2'b00, lct1_q};
      frame_d[63:61]  = pop_n;
      for (int i = 0; i < N_SLOTS; i++) begin
        if (3'(i) < pop_n) frame_d[55 - SLOT_W*i -: SLOT_W] = window[i];
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      bx_cnt <= '0;
    end else if (bc0) begin
      bx_cnt <= '0;
    end else if (bx_cnt == BX_W'(BX_MAX)) begin
      bx_cnt <= '0;
    end else begin
      bx_cnt <= bx_cnt + BX_W'(1);
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      frame            <= '0;
      gbt_tx_datavalid <= 1'b0;
      daq_overflow     <= 1'b0;
    end else begin
      frame            <= frame_d;
      gbt_tx_datavalid <= (state_q == RUN);
      if (daq_vld_q && fifo_full) daq_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alct_gbt_frame_builder.sv
// Bench for alct_gbt_frame_builder: directed stimulus; DAQ words go through a
// scoreboard queue popped by a frame monitor, other fields are checked inline.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_alct_gbt_frame_builder;
  import alct_gbt_pkg::*;

  logic               clock = 1'b0;
  logic               nreset;
  logic               gbt_txrdy;
  logic               bc0;
  logic [LCT_W-1:0]   lct0_word;
  logic [LCT_W-1:0]   lct1_word;
  logic               daq_we;
  logic [6:0]         daq_data;
  logic               daq_special;
  logic [FRAME_W-1:0] frame;
  logic               gbt_tx_datavalid;
  logic               daq_overflow;
  logic [1:0]         state_dbg;

  alct_gbt_frame_builder dut (
    .clock            (clock),
    .nreset           (nreset),
    .gbt_txrdy        (gbt_txrdy),
    .bc0              (bc0),
    .lct0_word        (lct0_word),
    .lct1_word        (lct1_word),
    .daq_we           (daq_we),
    .daq_data         (daq_data),
    .daq_special      (daq_special),
    .frame            (frame),
    .gbt_tx_datavalid (gbt_tx_datavalid),
    .daq_overflow     (daq_overflow),
    .state_dbg        (state_dbg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] w;
    int         due;   // cycle the word must appear, -1 = any time
  } exp_t;

  exp_t exp_q[$];
  int   obs_n[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   popped_total = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [LCT_W-1:0] mk_lct(input logic v, input logic [1:0] q, input logic a,
                                              input logic [6:0] key, input logic [2:0] bxn);
    logic [LCT_W-1:0] w;
    w = '0;
    w[LCT_VALID_BIT]      = v;
    w[LCT_QUAL_LSB +: 2]  = q;
    w[LCT_AMU_BIT]        = a;
    w[LCT_KEY_LSB +: 7]   = key;
    w[LCT_BXN_LSB +: 3]   = bxn;
    return w;
  endfunction

  task automatic push_word(input logic sp, input logic [6:0] d, input int due);
    exp_t e;
    e.w = {sp, d};
    e.due = due;
    exp_q.push_back(e);
  endtask

  // Frame monitor: consumes DAQ slots of every RUN frame against the scoreboard.
  always @(negedge clock) begin : mon
    int n;
    logic [7:0] slot;
    exp_t e;
    if (nreset) begin
      chk("datavalid_vs_header", gbt_tx_datavalid, frame[111:108] == HDR_RUN);
      if (frame[111:108] == HDR_RUN) begin
        n = int'(frame[63:61]);
        chk("pad_bits_zero", frame[60:56], 5'd0);
        if (n != 0) obs_n.push_back(n);
        for (int i = 0; i < N_SLOTS; i++) begin
          slot = frame[55 - 8*i -: 8];
          if (i < n) begin
            if (exp_q.size() == 0) begin
              fail_now("daq_unexpected_word");
            end else begin
              e = exp_q.pop_front();
              chk("daq_word", slot, e.w);
              if (e.due >= 0) chk("daq_latency", cyc, e.due);
              popped_total++;
            end
          end else begin
            chk("unused_slot_zero", slot, 8'd0);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int k;
    nreset = 1'b0; gbt_txrdy = 1'b0; bc0 = 1'b0;
    lct0_word = '0; lct1_word = '0;
    daq_we = 1'b0; daq_data = '0; daq_special = 1'b0;

    // Reset values
    #3;
    chk("rst_frame", frame, '0);
    chk("rst_datavalid", gbt_tx_datavalid, 1'b0);
    chk("rst_overflow", daq_overflow, 1'b0);
    chk("rst_state", state_dbg, 2'd0);
    repeat (3) @(negedge clock);
    nreset = 1'b1;

    // Handshake: three IDLE frames, txrdy rises, then IDLE, 16 SYNC, RUN
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle_header", frame[111:108], HDR_IDLE);
      chk("idle_bx", frame[107:96], 12'(i));
      chk("idle_payload_zero", frame[95:0], 96'd0);
    end
    gbt_txrdy = 1'b1;
    @(negedge clock);
    chk("hs_last_idle", frame[111:108], HDR_IDLE);
    chk("hs_state_sync", state_dbg, 2'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      chk("hs_sync_header", frame[111:108], HDR_SYNC);
      chk("hs_sync_dv", gbt_tx_datavalid, 1'b0);
    end
    @(negedge clock);
    chk("hs_run_header", frame[111:108], HDR_RUN);
    chk("hs_run_dv", gbt_tx_datavalid, 1'b1);
    chk("hs_state_run", state_dbg, 2'd2);

    // LCT fields: visible two edges after being driven
    lct0_word = mk_lct(1'b1, 2'd3, 1'b0, 7'h55, 3'd5);
    lct1_word = mk_lct(1'b1, 2'd1, 1'b1, 7'h2a, 3'd2);
    @(negedge clock);
    chk("lct0_not_early", frame[95:80], 16'h0000);
    @(negedge clock);
    chk("lct0_field", frame[95:80], 16'h3AAD);
    chk("lct1_field", frame[79:64], 16'h2D52);
    lct0_word = 14'h3FFF;
    lct1_word = 14'h0001;
    repeat (2) @(negedge clock);
    chk("lct0_all_ones", frame[95:80], 16'h3FFF);
    chk("lct1_one", frame[79:64], 16'h0001);

    // DAQ packing: one word per cycle, each alone in slot 0 two edges after write
    obs_n.delete();
    for (int i = 1; i <= 10; i++) begin
      daq_we = 1'b1; daq_data = 7'(i); daq_special = (i == 10);
      push_word(daq_special, daq_data, cyc + 3);
      @(negedge clock);
    end
    daq_we = 1'b0; daq_special = 1'b0;
    repeat (4) @(negedge clock);
    chk("pack_frame_count", obs_n.size(), 10);
    foreach (obs_n[i]) chk("pack_n_is_1", obs_n[i], 1);

    // Backlog while the link is down, then 7,7,6
    gbt_txrdy = 1'b0;
    @(negedge clock);
    obs_n.delete();
    for (int i = 0; i < 20; i++) begin
      daq_we = 1'b1; daq_data = 7'(8'h20 + i); daq_special = (i % 3 == 0);
      push_word(daq_special, daq_data, -1);
      @(negedge clock);
    end
    daq_we = 1'b0; daq_special = 1'b0;
    @(negedge clock);
    gbt_txrdy = 1'b1;
    repeat (24) @(negedge clock);
    chk("backlog_frames", obs_n.size(), 3);
    if (obs_n.size() == 3) begin
      chk("backlog_n0", obs_n[0], 7);
      chk("backlog_n1", obs_n[1], 7);
      chk("backlog_n2", obs_n[2], 6);
    end
    chk("backlog_no_overflow", daq_overflow, 1'b0);
    chk("backlog_drained", exp_q.size(), 0);

    // Overflow: DAQ_DEPTH + 3 writes, the last three are dropped
    gbt_txrdy = 1'b0;
    @(negedge clock);
    base = popped_total;
    for (int i = 0; i < 67; i++) begin
      if (i == 65) chk("ovf_not_yet", daq_overflow, 1'b0);
      daq_we = 1'b1; daq_data = 7'(i + 40); daq_special = i[0];
      if (i < 64) push_word(daq_special, daq_data, -1);
      @(negedge clock);
    end
    daq_we = 1'b0; daq_special = 1'b0;
    repeat (2) @(negedge clock);
    chk("ovf_set", daq_overflow, 1'b1);
    gbt_txrdy = 1'b1;
    repeat (40) @(negedge clock);
    chk("ovf_drained_count", popped_total - base, 64);
    chk("ovf_queue_empty", exp_q.size(), 0);
    chk("ovf_sticky", daq_overflow, 1'b1);

    // Link drop for one cycle while 5 words arrive
    for (int j = 0; j < 20; j++) begin
      gbt_txrdy = (j != 0);
      daq_we = (j < 5); daq_data = 7'(8'h60 + j); daq_special = (j == 4);
      if (j < 5) push_word(daq_special, daq_data, -1);
      @(negedge clock);
      if (j == 0 || j >= 18)      chk("drop_run_header", frame[111:108], HDR_RUN);
      else if (j == 1)            chk("drop_idle_header", frame[111:108], HDR_IDLE);
      else                        chk("drop_sync_header", frame[111:108], HDR_SYNC);
      if (j == 0)  chk("drop_frame_empty", frame[63:61], 3'd0);
      if (j == 18) chk("drop_n5", frame[63:61], 3'd5);
    end
    daq_we = 1'b0; daq_special = 1'b0;
    repeat (2) @(negedge clock);
    chk("drop_delivered", exp_q.size(), 0);

    // BX counter wrap and bc0
    k = 0;
    while (frame[107:96] != 12'd3563 && k < 4000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 4000) fail_now("bx_wait_3563_timeout");
    @(negedge clock);
    chk("bx_wrap_to_0", frame[107:96], 12'd0);
    @(negedge clock);
    chk("bx_after_wrap", frame[107:96], 12'd1);
    k = 0;
    while (frame[107:96] != 12'd100 && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (k >= 200) fail_now("bx_wait_100_timeout");
    bc0 = 1'b1;
    @(negedge clock);
    bc0 = 1'b0;
    chk("bx_bc0_sample_frame", frame[107:96], 12'd101);
    @(negedge clock);
    chk("bx_bc0_zero", frame[107:96], 12'd0);
    @(negedge clock);
    chk("bx_bc0_then_1", frame[107:96], 12'd1);

    // Asynchronous reset in RUN
    chk("pre_reset_run", frame[111:108], HDR_RUN);
    @(posedge clock);
    #2;
    nreset = 1'b0;
    #1;
    chk("arst_frame", frame, '0);
    chk("arst_datavalid", gbt_tx_datavalid, 1'b0);
    chk("arst_overflow", daq_overflow, 1'b0);
    chk("arst_state", state_dbg, 2'd0);
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    chk("post_rst_header", frame[111:108], HDR_IDLE);
    chk("post_rst_bx", frame[107:96], 12'd0);
    chk("post_rst_payload", frame[95:0], 96'd0);
    @(negedge clock);
    chk("post_rst_sync", frame[111:108], HDR_SYNC);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
